jk_step_controller: RTL
=======================

# jk_step_controller

Front-end stage that drives the JK flip-flop from lab push-buttons and checks its behaviour. It synchronises and debounces three raw buttons. On each press of the step button it issues exactly one J/K command, one clock wide, to the downstream negative-edge JK flip-flop. It also keeps a reference model of Q, counts steps, and raises a sticky error if the flip-flop's Q ever disagrees with the model.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a debounced input changes; legal range ≥ 1.
- CNT_W, 8: width of the step counter.

- clk  in  1  system clock; this block is posedge-triggered and shares clk with the flip-flop.
- reset  in  1  asynchronous, active-high; shared with the flip-flop.
- btn_j  in  1  raw J switch, asynchronous.
- btn_k  in  1  raw K switch, asynchronous.
- btn_step  in  1  raw step button, asynchronous; active-high.
- q_in  in  1  Q from the JK flip-flop.
- j_out  out  1  J drive to the flip-flop.
- k_out  out  1  K drive to the flip-flop.
- busy  out  1  high while a step is in progress (DRIVE or CHECK state).
- step_count  out  CNT_W  number of completed steps, modulo 2^CNT_W.
- q_model  out  1  expected Q.
- mismatch  out  1  sticky error flag: q_in differed from q_model.

## Operation
- Synchroniser: each raw button passes through 2 flops; reset value 0.
- Debounce, per input:
  - The debounced value starts at 0.
  - A counter increments on each cycle where the synchronised value differs from the debounced value.
  - The counter clears on any cycle where they are equal.
  - When the count reaches DEBOUNCE_CYCLES, the debounced value takes the synchronised value and the counter clears.
- step_req = db_step & ~db_step_d. This is a one-cycle pulse on the rising edge of the debounced step button; release generates nothing.
- FSM states: IDLE, DRIVE, CHECK. Reset state is IDLE.
  - IDLE:
    - j_out = k_out = 0.
    - On step_req, latch cmd_j = db_j and cmd_k = db_k, then go to DRIVE.
  - DRIVE:
    - j_out = cmd_j, k_out = cmd_k, held for exactly one clk period.
    - On exit, update q_model: 00 keeps it, 01 sets it to 0, 10 sets it to 1, 11 inverts it.
    - On exit, step_count increments and wraps from 2^CNT_W−1 to 0.
    - Always go to CHECK.
  - CHECK:
    - j_out = k_out = 0.
    - On exit, if q_in != q_model, set mismatch.
    - Always go to IDLE.
- step_req arriving in DRIVE or CHECK is dropped, not queued. A new step requires the button to be released and pressed again.
- Command 00 still counts as a step and is still checked.
- mismatch stays set until reset. Stepping continues normally after it is set.
- All outputs are registered.

## Timing
- Reset values, applied asynchronously and immediately: j_out 0, k_out 0, busy 0, step_count 0, q_model 0, mismatch 0, FSM in IDLE, all synchroniser and debounce state 0.
- Reset mid-step aborts the step. j_out and k_out drop to 0 at once. The flip-flop resets alongside, so q_model = Q = 0 remains consistent.
- Latency from step press: if btn_step is first sampled high at posedge N and stays high, step_req is high in the cycle after posedge N+D+1, where D = DEBOUNCE_CYCLES. j_out/k_out become valid after posedge N+D+2.
- J/K setup: btn_j and btn_k must reach their debounced values before step_req. The latched values are those at the posedge that enters DRIVE.
- The flip-flop samples j_out/k_out at the negedge in the middle of DRIVE. Q settles before CHECK begins, and q_in is compared at the posedge leaving CHECK.
- busy is high for exactly 2 cycles per step. The minimum interval between steps is bounded by debounce release plus press: 2·(D+1) cycles.
- step_count and q_model update at the same posedge (the one leaving DRIVE). mismatch updates one cycle later.

## Test plan
- Reset then press step with J=1, K=0 (D=4):
  - j_out=1 for exactly one cycle, 7 posedges after the raw press.
  - Then q_model=1, q_in=1, step_count=1, mismatch stays 0.
- Four steps with JK=11 starting from Q=0:
  - q_model follows 1, 0, 1, 0.
  - step_count=4 and mismatch=0.
- Bounce: toggle btn_step every 2 cycles for 20 cycles, then hold it high:
  - Exactly one DRIVE occurs.
  - No j_out/k_out activity during the bouncing.
- Fault: force q_in=0 while stepping with JK=10:
  - mismatch rises at the posedge leaving CHECK.
  - It stays 1 through later correct steps until reset.
- Step held continuously, or a second press during busy:
  - Only one step is counted.
  - With CNT_W=2, five steps give step_count=1 (wrap check).
- Assert reset during DRIVE with JK=10:
  - j_out drops to 0 immediately; q_model=0, step_count=0, FSM in IDLE.
  - After release, the next step works normally.

Source files
------------

// File: rtl/jk_step_controller.sv
// jk_step_controller: push-button front end for a negative-edge JK flip-flop.
// Debounces J/K/step, issues one-cycle J/K commands and checks Q against a model.
module jk_step_controller #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_j,
   input  logic             btn_k,
   input  logic             btn_step,
   input  logic             q_in,
   output logic             j_out,
   output logic             k_out,
   output logic             busy,
   output logic [CNT_W-1:0] step_count,
   output logic             q_model,
   output logic             mismatch
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

   // Bit 0 = J, bit 1 = K, bit 2 = step.
   localparam int BJ = 0;
   localparam int BK = 1;
   localparam int BS = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   logic [2:0]          raw;
   logic [2:0]          sync1_q;
   logic [2:0]          sync2_q;
   logic [2:0]          db_q;
   logic [2:0]          db_d;
   logic [2:0][DBW-1:0] dbc_q;
   logic [2:0][DBW-1:0] dbc_d;
   logic                db_step_dly_q;
   logic                step_req;

   state_t              state_q;
   state_t              state_d;
   logic                j_q;
   logic                j_d;
   logic                k_q;
   logic                k_d;
   logic                busy_q;
   logic                busy_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic                qm_q;
   logic                qm_d;
   logic                mism_q;
   logic                mism_d;

   assign raw = {btn_step, btn_k, btn_j};

   // Two-flop synchroniser for the asynchronous buttons.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: a change is accepted after DEBOUNCE_CYCLES consecutive differing cycles.
   always_comb begin
      db_d  = db_q;
      dbc_d = '0;
      for (int i = 0; i < 3; i++) begin
         if (sync2_q[i] != db_q[i]) begin
            if (dbc_q[i] == DB_LAST) begin
               db_d[i] = sync2_q[i];
            end else begin
               dbc_d[i] = dbc_q[i] + 1'b1;
            end
         end
      end
   end

   // Debounce state and the delayed step level for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_q          <= '0;
         dbc_q         <= '0;
         db_step_dly_q <= 1'b0;
      end else begin
         db_q          <= db_d;
         dbc_q         <= dbc_d;
         db_step_dly_q <= db_q[BS];
      end
   end

   // Press edge only; releases and held buttons produce nothing.
   assign step_req = db_q[BS] & ~db_step_dly_q;

   // Next state and next registered outputs.
   always_comb begin
      state_d = state_q;
      j_d     = 1'b0;
      k_d     = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = cnt_q;
      qm_d    = qm_q;
      mism_d  = mism_q;
      unique case (state_q)
         S_IDLE: begin
            if (step_req) begin
               state_d = S_DRIVE;
               j_d     = db_q[BJ];
               k_d     = db_q[BK];
               busy_d  = 1'b1;
            end
         end
         S_DRIVE: begin
            state_d = S_CHECK;
            busy_d  = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            unique case ({j_q, k_q})
               2'b00:   qm_d = qm_q;
               2'b01:   qm_d = 1'b0;
               2'b10:   qm_d = 1'b1;
               2'b11:   qm_d = ~qm_q;
               default: qm_d = qm_q;
            endcase
         end
         S_CHECK: begin
            state_d = S_IDLE;
            if (q_in != qm_q) begin
               mism_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         j_q     <= 1'b0;
         k_q     <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         qm_q    <= 1'b0;
         mism_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         k_q     <= k_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         qm_q    <= qm_d;
         mism_q  <= mism_d;
      end
   end

   assign j_out      = j_q;
   assign k_out      = k_q;
   assign busy       = busy_q;
   assign step_count = cnt_q;
   assign q_model    = qm_q;
   assign mismatch   = mism_q;

endmodule
